// File: rtl/instruction_fetch_pkg.sv
// Shared cpu definitions: fetch FSM encoding, instruction geometry and decoder field positions.
// Imported by the fetch stage and its output buffer.
package instruction_fetch_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;

    // Instruction field positions consumed by the decoder.
    localparam int ALUOP_MSB = 31;
    localparam int ALUOP_LSB = 29;
    localparam int RS1_MSB   = 28;
    localparam int RS1_LSB   = 24;
    localparam int RS2_MSB   = 23;
    localparam int RS2_LSB   = 19;
    localparam int RD_MSB    = 18;
    localparam int RD_LSB    = 14;
    localparam int IMM_MSB   = 13;
    localparam int IMM_LSB   = 0;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_WAIT  = 2'd1,
        ST_FULL  = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
    } fetch_entry_t;

    typedef struct packed {
        logic [ALUOP_MSB-ALUOP_LSB:0] aluop;
        logic [RS1_MSB-RS1_LSB:0]     rs1;
        logic [RS2_MSB-RS2_LSB:0]     rs2;
        logic [RD_MSB-RD_LSB:0]       rd;
        logic [IMM_MSB-IMM_LSB:0]     imm;
    } instr_fields_t;

    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
        return addr & ~32'd3;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] low_bits);
        return low_bits != 2'b00;
    endfunction

endpackage

// File: rtl/instruction_fetch_out_buffer.sv
// One-entry valid/ready holding register carrying {instr, pc} from fetch to decode.
// A flush wins over a load or a consume in the same cycle; payload is held while not loaded.
module if_out_buffer
    import instruction_fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    input  fetch_entry_t in_data,
    input  logic         out_ready,
    output logic         out_valid,
    output fetch_entry_t out_data,
    output logic         out_fire
);

    logic         valid_reg;
    fetch_entry_t data_reg;

    assign out_valid = valid_reg;
    assign out_data  = data_reg;
    assign out_fire  = valid_reg & out_ready & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg <= 1'b0;
            data_reg  <= '0;
        end else if (flush) begin
            valid_reg <= 1'b0;
        end else if (in_valid) begin
            valid_reg <= 1'b1;
            data_reg  <= in_data;
        end else if (out_fire) begin
            valid_reg <= 1'b0;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: one outstanding memory request, a one-entry buffer towards decode,
// and redirect handling that squashes in-flight responses.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        if_ready,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic        misalign_err,
    output logic [31:0] fetch_count
);

    fetch_state_e state_reg, state_next;

    logic [31:0]  pc_reg, pc_next;
    logic [31:0]  pc_inflight_reg, pc_inflight_next;
    logic         drop_pending_reg, drop_pending_next;
    logic         misalign_reg;
    logic [31:0]  fetch_count_reg;

    logic         buf_load;
    logic         buf_valid;
    logic         buf_fire;
    fetch_entry_t buf_in;
    fetch_entry_t buf_out;

    // A response is kept only if nothing asked for it to be squashed.
    assign buf_load = (state_reg == ST_WAIT) & imem_rsp_valid
                    & ~drop_pending_reg & ~redirect_valid;
    assign buf_in   = '{instr: imem_rsp_data, pc: pc_inflight_reg};

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            // An accepted request is outstanding even if a redirect cancels it.
            ST_FETCH: begin
                if (imem_req_ready) begin
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem_rsp_valid) begin
                    state_next = (redirect_valid || drop_pending_reg) ? ST_FETCH : ST_FULL;
                end
            end
            ST_FULL: begin
                if (redirect_valid || buf_fire) begin
                    state_next = ST_FETCH;
                end
            end
            default: state_next = ST_FETCH;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        imem_req_valid = rst_n & (state_reg == ST_FETCH);
        imem_addr      = pc_reg;
    end

    // ---------------- datapath next values ----------------
    always_comb begin
        pc_next           = pc_reg;
        pc_inflight_next  = pc_inflight_reg;
        drop_pending_next = drop_pending_reg;

        case (state_reg)
            ST_FETCH: begin
                if (imem_req_ready) begin
                    pc_inflight_next  = pc_reg;
                    drop_pending_next = redirect_valid;
                end
            end
            ST_WAIT: begin
                if (imem_rsp_valid) begin
                    drop_pending_next = 1'b0;
                    if (!drop_pending_reg) begin
                        pc_next = pc_inflight_reg + 32'(PC_STEP);
                    end
                end else if (redirect_valid) begin
                    drop_pending_next = 1'b1;
                end
            end
            default: ;
        endcase

        if (redirect_valid) begin
            pc_next = word_align(redirect_pc);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_reg           <= RESET_PC;
            pc_inflight_reg  <= RESET_PC;
            drop_pending_reg <= 1'b0;
            misalign_reg     <= 1'b0;
            fetch_count_reg  <= '0;
        end else begin
            pc_reg           <= pc_next;
            pc_inflight_reg  <= pc_inflight_next;
            drop_pending_reg <= drop_pending_next;
            misalign_reg     <= redirect_valid & is_misaligned(redirect_pc[1:0]);
            if (buf_fire) begin
                fetch_count_reg <= fetch_count_reg + 32'd1;
            end
        end
    end

    if_out_buffer u_out_buffer (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect_valid),
        .in_valid  (buf_load),
        .in_data   (buf_in),
        .out_ready (if_ready),
        .out_valid (buf_valid),
        .out_data  (buf_out),
        .out_fire  (buf_fire)
    );

    assign if_valid     = buf_valid;
    assign if_instr     = buf_out.instr;
    assign if_pc        = buf_out.pc;
    assign misalign_err = misalign_reg;
    assign fetch_count  = fetch_count_reg;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios followed by randomized traffic, checked against
// a model of the decode stream (consecutive addresses, restarting at each aligned redirect target).
module tb_instruction_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int unsigned PC_STEP  = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_ready;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        misalign_err;
    logic [31:0] fetch_count;

    always #5 clk = ~clk;

    instruction_fetch #(.RESET_PC(RESET_PC), .PC_STEP(PC_STEP)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_ready       (if_ready),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .misalign_err   (misalign_err),
        .fetch_count    (fetch_count)
    );

    int          n_cmp = 0;
    int          n_err = 0;

    // Memory model and decode-stream reference
    bit          pending;
    logic [31:0] pend_addr;
    int          lat;
    int          lat_fixed;
    bit          lat_rand;
    logic [31:0] exp_pc;
    logic [31:0] ndeliv;
    bit          exp_mis;
    logic [31:0] hold_instr;
    logic [31:0] hold_pc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'hC000_4001;
        return {a[15:0] ^ 16'h3C5A, a[31:16] ^ 16'h0F0F};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, account for handshakes, advance, check.
    task automatic step(input bit rdy, input bit ifr, input bit redir,
                        input logic [31:0] rpc, input bit spur);
        bit rsp;
        bit accept;
        bit deliver;
        imem_req_ready = rdy;
        if_ready       = ifr;
        redirect_valid = redir;
        redirect_pc    = rpc;
        rsp = 1'b0;
        if (pending) begin
            if (lat == 0) rsp = 1'b1;
            else lat--;
        end else if (spur) begin
            rsp = 1'b1;
        end
        imem_rsp_valid = rsp;
        imem_rsp_data  = (pending && rsp) ? mem_word(pend_addr) : $urandom;
        accept  = imem_req_valid && rdy;
        deliver = if_valid && ifr && !redir;
        if (deliver) begin
            $display("deliver pc=%h instr=%h", if_pc, if_instr);
            chk("dec_pc", if_pc, exp_pc);
            chk("dec_instr", if_instr, mem_word(exp_pc));
            exp_pc = exp_pc + PC_STEP;
            ndeliv = ndeliv + 32'd1;
        end
        if (pending && rsp) pending = 1'b0;
        if (accept) begin
            pending   = 1'b1;
            pend_addr = imem_addr;
            lat       = lat_rand ? int'($urandom_range(0, 3)) : lat_fixed;
        end
        if (redir) begin
            exp_pc  = rpc & ~32'd3;
            exp_mis = (rpc[1:0] != 2'b00);
        end else begin
            exp_mis = 1'b0;
        end
        @(posedge clk);
        #1;
        chk("fetch_count", fetch_count, ndeliv);
        chk("misalign_err", {31'd0, misalign_err}, {31'd0, exp_mis});
        if (pending) chk("req_while_outstanding", {31'd0, imem_req_valid}, 32'd0);
    endtask

    task automatic idle_inputs();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        if_ready       = 1'b0;
    endtask

    task automatic model_reset();
        pending = 1'b0;
        lat     = 0;
        exp_pc  = RESET_PC;
        ndeliv  = 32'd0;
        exp_mis = 1'b0;
    endtask

    task automatic reset_checks(input string phase);
        chk({phase, "_req_valid"}, {31'd0, imem_req_valid}, 32'd0);
        chk({phase, "_addr"}, imem_addr, RESET_PC);
        chk({phase, "_if_valid"}, {31'd0, if_valid}, 32'd0);
        chk({phase, "_if_instr"}, if_instr, 32'd0);
        chk({phase, "_if_pc"}, if_pc, 32'd0);
        chk({phase, "_misalign"}, {31'd0, misalign_err}, 32'd0);
        chk({phase, "_fetch_count"}, fetch_count, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        model_reset();
        lat_fixed  = 0;
        lat_rand   = 1'b0;
        pend_addr  = 32'h0;
        hold_instr = 32'h0;
        hold_pc    = 32'h0;

        repeat (3) @(posedge clk);
        #1;
        reset_checks("reset");

        // Release: request visible immediately at RESET_PC
        rst_n = 1'b1;
        #1;
        chk("first_req_valid", {31'd0, imem_req_valid}, 32'd1);
        chk("first_req_addr", imem_addr, RESET_PC);

        // 1-cycle memory: fetch word at 0
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("first_if_valid", {31'd0, if_valid}, 32'd1);
        chk("first_if_instr", if_instr, 32'hC000_4001);
        chk("first_if_pc", if_pc, 32'h0);

        // Decode stalls for 5 cycles
        hold_instr = if_instr;
        hold_pc    = if_pc;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
            chk("stall_instr", if_instr, hold_instr);
            chk("stall_pc", if_pc, hold_pc);
            chk("stall_req_valid", {31'd0, imem_req_valid}, 32'd0);
            chk("stall_if_valid", {31'd0, if_valid}, 32'd1);
        end
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("consume_if_valid", {31'd0, if_valid}, 32'd0);
        chk("next_req_valid", {31'd0, imem_req_valid}, 32'd1);
        chk("next_req_addr", imem_addr, 32'h4);

        // Redirect to 0x100 while a response is outstanding
        lat_fixed = 2;
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 32'h100, 1'b0);
        chk("wait_redir_req_valid", {31'd0, imem_req_valid}, 32'd0);
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
            chk("dropped_if_valid", {31'd0, if_valid}, 32'd0);
        end
        chk("post_drop_req_valid", {31'd0, imem_req_valid}, 32'd1);
        chk("post_drop_addr", imem_addr, 32'h100);

        // Misaligned redirect coincident with the response
        lat_fixed = 0;
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 32'h102, 1'b0);
        chk("misalign_pulse", {31'd0, misalign_err}, 32'd1);
        chk("rsp_redir_if_valid", {31'd0, if_valid}, 32'd0);
        chk("rsp_redir_addr", imem_addr, 32'h100);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("misalign_once", {31'd0, misalign_err}, 32'd0);
        chk("aligned_req_valid", {31'd0, imem_req_valid}, 32'd1);
        chk("aligned_addr", imem_addr, 32'h100);

        // Sequential wrap at the top of the address space
        step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
        chk("wrap_req_addr", imem_addr, 32'hFFFF_FFFC);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("wrap_if_pc", if_pc, 32'hFFFF_FFFC);
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("wrap_next_addr", imem_addr, 32'h0);
        chk("wrap_count", fetch_count, 32'd2);

        // Reset during WAIT, stale response right after release
        lat_fixed = 3;
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("pre_reset_wait", {31'd0, imem_req_valid}, 32'd0);
        idle_inputs();
        rst_n = 1'b0;
        model_reset();
        #1;
        reset_checks("midreset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("rerelease_req_valid", {31'd0, imem_req_valid}, 32'd1);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("stale_if_valid", {31'd0, if_valid}, 32'd0);
        chk("stale_req_valid", {31'd0, imem_req_valid}, 32'd1);
        chk("stale_addr", imem_addr, RESET_PC);

        // Randomized traffic
        lat_rand = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            bit          rdy;
            bit          ifr;
            bit          redir;
            bit          spur;
            logic [31:0] rpc;
            rdy   = ($urandom % 10) < 6;
            ifr   = ($urandom % 2) == 0;
            redir = ($urandom % 25) == 0;
            spur  = ($urandom % 8) == 0;
            rpc   = $urandom;
            if (($urandom % 4) == 0) rpc = 32'hFFFF_FFF0 | ($urandom % 16);
            step(rdy, ifr, redir, rpc, spur);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
